seq_bin_divider: RTL

- Sequential restoring shift-subtract unsigned divider.
- Divides a 2W-bit dividend by a W-bit divisor, producing a W-bit quotient and a W-bit remainder.
- Inverse companion of the team's sequential shift-add multiplier. Uses the same start/rdy handshake and the same controller/datapath split, so one bench harness can drive both (product from the multiplier feeds the dividend here).
- Early exit on a zero dividend, plus divide-by-zero and quotient-overflow detection.

---
 rtl/seq_bin_divider.sv | 129 ++++++++++++
 1 files changed

// File: rtl/seq_bin_divider.sv
// Restoring shift-subtract divider, 2W/W -> W quotient + W remainder; 2+2W cycles (2 on early exit/error).
// Accepts start only while rdy=1; inputs are ignored while busy and results hold until the next accept.
module seq_bin_divider #(
  parameter int DP_WIDTH = 5,
  parameter int BC_SIZE  = 3
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    start,
  input  logic [2*DP_WIDTH-1:0]   dividend,
  input  logic [DP_WIDTH-1:0]     divisor,
  output logic [DP_WIDTH-1:0]     quotient,
  output logic [DP_WIDTH-1:0]     remainder,
  output logic                    rdy,
  output logic                    div_by_zero,
  output logic                    overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_SUB   = 2'd3;

  localparam logic [BC_SIZE-1:0] P_INIT = BC_SIZE'(DP_WIDTH);

  logic [1:0]          state, next_state;
  logic [DP_WIDTH-1:0] a, q, b;
  logic                c;
  logic [BC_SIZE-1:0]  p;

  logic load_regs, clr_regs, set_dbz, set_ovf, shift_regs, decr_p, sub_regs;

  always_comb begin
    next_state = state;
    load_regs  = 1'b0;
    clr_regs   = 1'b0;
    set_dbz    = 1'b0;
    set_ovf    = 1'b0;
    shift_regs = 1'b0;
    decr_p     = 1'b0;
    sub_regs   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load_regs  = 1'b1;
          next_state = S_CHECK;
        end
      end
      S_CHECK: begin
        if (b == '0) begin
          set_dbz    = 1'b1;
          clr_regs   = 1'b1;
          next_state = S_IDLE;
        end else if (a >= b) begin
          // Upper half >= divisor means the quotient needs more than W bits.
          set_ovf    = 1'b1;
          clr_regs   = 1'b1;
          next_state = S_IDLE;
        end else if ({a, q} == '0) begin
          next_state = S_IDLE;
        end else begin
          next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_regs = 1'b1;
        decr_p     = 1'b1;
        next_state = S_SUB;
      end
      default: begin
        sub_regs   = 1'b1;
        next_state = (p == '0) ? S_IDLE : S_SHIFT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a           <= '0;
      q           <= '0;
      b           <= '0;
      c           <= 1'b0;
      p           <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (load_regs) begin
        a           <= dividend[2*DP_WIDTH-1:DP_WIDTH];
        q           <= dividend[DP_WIDTH-1:0];
        b           <= divisor;
        p           <= P_INIT;
        c           <= 1'b0;
        div_by_zero <= 1'b0;
        overflow    <= 1'b0;
      end
      if (clr_regs) begin
        a <= '0;
        q <= '0;
      end
      if (set_dbz) div_by_zero <= 1'b1;
      if (set_ovf) overflow    <= 1'b1;
      if (shift_regs) begin
        {c, a, q} <= {a, q, 1'b0};
      end
      if (decr_p) p <= p - BC_SIZE'(1);
      if (sub_regs) begin
        // C holds the bit shifted out of A, so A-B wraps to the true partial remainder.
        if (c || (a >= b)) begin
          a    <= a - b;
          q[0] <= 1'b1;
        end
        c <= 1'b0;
      end
    end
  end

  assign rdy       = (state == S_IDLE);
  assign quotient  = q;
  assign remainder = a;

endmodule
